bit_serial_adder_ctrl: RTL and testbench

Sequencer that time-multiplexes a single full_adder cell to perform a WIDTH-bit addition LSB-first, one bit per clock. It holds the operand and sum shift registers and the carry flip-flop, and runs a small FSM. Operands enter and results leave through valid/ready handshakes. It sits between an operand producer and a result consumer in the area-minimal arithmetic path.

---
 rtl/arith_pkg.sv | 19 +
 rtl/full_adder.sv | 13 +
 rtl/bit_serial_adder_ctrl.sv | 102 ++++++++++
 tb/tb_bit_serial_adder_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared types and helpers for the serial arithmetic path.
package arith_pkg;

    // Sequencer states for the bit-serial adder.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter width: enough to hold w-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        int c;
        c = 0;
        while ((1 << c) < w) c++;
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the datapath element reused every cycle.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one shared full adder walks WIDTH bits LSB-first.
// Operands arrive and sums leave through valid/ready handshakes.
module bit_serial_adder_ctrl
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry_q;
    logic             r_out_cout;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s;
    logic             w_cout;
    logic [WIDTH-1:0] w_sum_next;

    full_adder u_fa (
        .i_a    (r_a_sh[0]),
        .i_b    (r_b_sh[0]),
        .i_cin  (r_carry_q),
        .o_s    (w_s),
        .o_cout (w_cout)
    );

    // New sum bit enters at the MSB so the LSB ends up at bit 0 after WIDTH steps.
    generate
        if (WIDTH == 1) begin : g_one
            assign w_sum_next = w_s;
        end else begin : g_wide
            assign w_sum_next = {w_s, r_sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // Handshake flags come straight from the registered state.
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_sum   = r_sum_sh;
    assign out_cout  = r_out_cout;

    // FSM with operand/sum shift registers, carry and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_sum_sh   <= '0;
            r_carry_q  <= 1'b0;
            r_out_cout <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sh    <= in_a;
                        r_b_sh    <= in_b;
                        r_carry_q <= in_cin;
                        r_cnt     <= '0;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    r_sum_sh  <= w_sum_next;
                    r_a_sh    <= r_a_sh >> 1;
                    r_b_sh    <= r_b_sh >> 1;
                    r_carry_q <= w_cout;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // Carry-out is captured separately so it survives the next load.
                        r_out_cout <= w_cout;
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Bench for bit_serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances.
module tb_bit_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [W-1:0] in_a, in_b, out_sum;
    logic         s1_in_valid, s1_in_ready, s1_in_cin, s1_out_valid, s1_out_ready;
    logic         s1_out_cout, s1_busy;
    logic [0:0]   s1_in_a, s1_in_b, s1_out_sum;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Abstract model: a job completes W cycles after acceptance, result = a+b+cin.
    logic       m_pend = 1'b0;
    int         m_left = 0;
    logic [8:0] m_res  = '0;
    logic [8:0] m_last = '0;
    int         m_nin  = 0;
    int         m_nout = 0;

    always #5 clk = ~clk;

    bit_serial_adder_ctrl #(.WIDTH(W)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    bit_serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .in_a(s1_in_a), .in_b(s1_in_b), .in_cin(s1_in_cin),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .out_sum(s1_out_sum), .out_cout(s1_out_cout), .busy(s1_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on the same edges the DUT sees.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
            m_last <= '0;
        end else if (!m_pend) begin
            if (in_valid) begin
                m_pend <= 1'b1;
                m_left <= W;
                m_res  <= 9'(in_a) + 9'(in_b) + 9'(in_cin);
                m_nin  <= m_nin + 1;
            end
        end else if (m_left > 0) begin
            if (m_left == 1) m_last <= m_res;
            m_left <= m_left - 1;
        end else if (out_ready) begin
            m_pend <= 1'b0;
            m_nout <= m_nout + 1;
        end
    end

    // Per-cycle comparison of the 8-bit instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_in_ready", 32'(in_ready), 32'(!m_pend));
            check("m_busy", 32'(busy), 32'(m_pend));
            check("m_out_valid", 32'(out_valid), 32'(m_pend && m_left == 0));
            if (!m_pend || m_left == 0)
                check("m_result", 32'({out_cout, out_sum}), 32'(m_last));
        end
    end

    // Wait for acceptance on the 8-bit instance; returns #1 after the accepting edge.
    task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        logic ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        check("accept_timeout", 32'(ok), 32'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input int stall,
                       input logic [7:0] exp_sum, input logic exp_cout);
        int   lat;
        logic seen;
        out_ready = (stall == 0);
        accept8(a, b, cin);
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_seen"}, 32'(seen), 32'(1));
        check({name, "_latency"}, 32'(lat), 32'(W));
        check({name, "_sum"}, 32'(out_sum), 32'(exp_sum));
        check({name, "_cout"}, 32'(out_cout), 32'(exp_cout));
        if (stall > 0) begin
            in_valid = 1'b1; in_a = ~a; in_b = b ^ 8'h3C; in_cin = ~cin;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check({name, "_stall_valid"}, 32'(out_valid), 32'(1));
                check({name, "_stall_sum"}, 32'(out_sum), 32'(exp_sum));
                check({name, "_stall_cout"}, 32'(out_cout), 32'(exp_cout));
                check({name, "_stall_in_ready"}, 32'(in_ready), 32'(0));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({name, "_drained"}, 32'(out_valid), 32'(0));
        check({name, "_in_ready_back"}, 32'(in_ready), 32'(1));
        check({name, "_hold_sum"}, 32'(out_sum), 32'(exp_sum));
        out_ready = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        logic ok;
        in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; out_ready = 0;
        s1_in_valid = 0; s1_in_a = '0; s1_in_b = '0; s1_in_cin = 0; s1_out_ready = 0;
        rst = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_result", 32'({out_cout, out_sum}), 32'(0));
        check("rst1_in_ready", 32'(s1_in_ready), 32'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        op8("ff_01", 8'hFF, 8'h01, 1'b0, 0, 8'h00, 1'b1);
        op8("5a_a5", 8'h5A, 8'hA5, 1'b1, 0, 8'h00, 1'b1);
        op8("12_34", 8'h12, 8'h34, 1'b0, 0, 8'h46, 1'b0);
        op8("stall", 8'h80, 8'h7F, 1'b1, 5, 8'h00, 1'b1);
        op8("c3_11", 8'hC3, 8'h11, 1'b1, 2, 8'hD5, 1'b0);

        // Abort mid-operation after three bits.
        accept8(8'hAA, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'(1));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_result", 32'({out_cout, out_sum}), 32'(0));
        @(posedge clk); #1 rst = 1'b0;
        op8("0f_f0", 8'h0F, 8'hF0, 1'b1, 0, 8'h00, 1'b1);

        // WIDTH=1 instance: 1+1+1 = 3.
        s1_in_a = 1'b1; s1_in_b = 1'b1; s1_in_cin = 1'b1; s1_in_valid = 1'b1; s1_out_ready = 1'b1;
        @(posedge clk); #1;
        s1_in_valid = 1'b0;
        check("w1_busy", 32'(s1_busy), 32'(1));
        lat = 0; ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (s1_out_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            lat++;
        end
        check("w1_seen", 32'(ok), 32'(1));
        check("w1_latency", 32'(lat), 32'(1));
        check("w1_sum", 32'(s1_out_sum), 32'(1));
        check("w1_cout", 32'(s1_out_cout), 32'(1));
        @(posedge clk); #1;
        check("w1_in_ready_back", 32'(s1_in_ready), 32'(1));

        // Random traffic with random gaps on both sides.
        m_nin = 0; m_nout = 0;
        for (int cyc = 0; cyc < 60000 && m_nin < 1000; cyc++) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            in_cin    = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (W + 4) @(posedge clk);
        #1;
        check("rand_in_count", 32'(m_nin), 32'(1000));
        check("rand_in_eq_out", 32'(m_nout), 32'(m_nin));
        check("rand_idle", 32'(in_ready), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
